// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - ordered write-back FIFO with per-register busy scoreboard
module reg_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        AluValid,
  input  logic [4:0]  AluReg,
  input  logic [31:0] AluData,
  input  logic        LdIssue,
  input  logic [4:0]  LdIssueReg,
  input  logic        LdValid,
  input  logic [4:0]  LdReg,
  input  logic [31:0] LdData,
  input  logic        JalValid,
  input  logic [31:0] JalPC,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  output logic        Stall,
  output logic        Busy1,
  output logic        Busy2,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]  fifo_reg  [DEPTH];
  logic [31:0] fifo_data [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [31:0] pending;

  logic [AW:0] count;
  logic        pop;
  logic [AW:0] free;
  logic        jal_req;
  logic        ld_req;
  logic        alu_req;
  logic        issue_req;
  logic        issue_conflict;
  logic [AW:0] n_req;
  logic        accept;
  logic [AW:0] wp_jal;
  logic [AW:0] wp_ld;
  logic [AW:0] wp_alu;

  // Occupancy, request qualification and the all-or-nothing accept decision
  always_comb begin
    count          = wr_ptr - rd_ptr;
    pop            = (count != '0);
    free           = (AW+1)'(DEPTH) - count + {{AW{1'b0}}, pop};
    jal_req        = JalValid;
    ld_req         = LdValid && (LdReg != 5'd0);
    alu_req        = AluValid && (AluReg != 5'd0);
    issue_req      = LdIssue && (LdIssueReg != 5'd0);
    issue_conflict = issue_req && pending[LdIssueReg];
    n_req          = {{AW{1'b0}}, jal_req} + {{AW{1'b0}}, ld_req} + {{AW{1'b0}}, alu_req};
    Stall          = issue_conflict || (n_req > free);
    accept         = !Stall;
    // Slots are packed in Jal, Ld, Alu order so the youngest same-register write retires last
    wp_jal         = wr_ptr;
    wp_ld          = wp_jal + {{AW{1'b0}}, jal_req};
    wp_alu         = wp_ld + {{AW{1'b0}}, ld_req};
  end

  // A register is busy while a load is outstanding, a write is queued, or the strobe is in flight
  function automatic logic busy_of(input logic [4:0] r);
    logic        hit;
    logic [AW:0] idx;
    hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + (AW+1)'(k);
      if (((AW+1)'(k) < count) && (fifo_reg[idx[AW-1:0]] == r))
        hit = 1'b1;
    end
    return (r != 5'd0) && (pending[r] || hit || (RegWrite && (WriteReg == r)));
  endfunction

  // Scoreboard queries for both decode read ports
  always_comb begin
    Busy1 = busy_of(ReadReg1);
    Busy2 = busy_of(ReadReg2);
  end

  // FIFO storage writes; contents need no reset because the pointers gate validity
  always_ff @(posedge Clk) begin
    if (accept) begin
      if (jal_req) begin
        fifo_reg[wp_jal[AW-1:0]]  <= 5'd31;
        fifo_data[wp_jal[AW-1:0]] <= JalPC + 32'd1;
      end
      if (ld_req) begin
        fifo_reg[wp_ld[AW-1:0]]  <= LdReg;
        fifo_data[wp_ld[AW-1:0]] <= LdData;
      end
      if (alu_req) begin
        fifo_reg[wp_alu[AW-1:0]]  <= AluReg;
        fifo_data[wp_alu[AW-1:0]] <= AluData;
      end
    end
  end

  // Pointer advance and head drain into the registered regfile write port
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      RegWrite  <= 1'b0;
      WriteReg  <= 5'd0;
      WriteData <= 32'd0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + n_req;
      if (pop) begin
        rd_ptr    <= rd_ptr + {{AW{1'b0}}, 1'b1};
        RegWrite  <= 1'b1;
        WriteReg  <= fifo_reg[rd_ptr[AW-1:0]];
        WriteData <= fifo_data[rd_ptr[AW-1:0]];
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

  // Outstanding-load tracking; a same-cycle issue to the returning register leaves it pending
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pending <= 32'd0;
    end else if (accept) begin
      if (ld_req)
        pending[LdReg] <= 1'b0;
      if (issue_req)
        pending[LdIssueReg] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb/tb_reg_writeback_queue.sv - directed self-checking bench for reg_writeback_queue
module tb_reg_writeback_queue;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        AluValid;
  logic [4:0]  AluReg;
  logic [31:0] AluData;
  logic        LdIssue;
  logic [4:0]  LdIssueReg;
  logic        LdValid;
  logic [4:0]  LdReg;
  logic [31:0] LdData;
  logic        JalValid;
  logic [31:0] JalPC;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic        Stall;
  logic        Busy1;
  logic        Busy2;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] wq[$];

  reg_writeback_queue #(.DEPTH(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData),
    .LdIssue(LdIssue), .LdIssueReg(LdIssueReg),
    .LdValid(LdValid), .LdReg(LdReg), .LdData(LdData),
    .JalValid(JalValid), .JalPC(JalPC),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .Stall(Stall), .Busy1(Busy1), .Busy2(Busy2),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
  );

  always #5 Clk = ~Clk;

  // Record every retired write as {reg, data}
  always @(negedge Clk) begin
    if (RegWrite)
      wq.push_back({WriteReg, WriteData});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    AluValid = 1'b0; AluReg = 5'd0; AluData = 32'd0;
    LdIssue  = 1'b0; LdIssueReg = 5'd0;
    LdValid  = 1'b0; LdReg = 5'd0; LdData = 32'd0;
    JalValid = 1'b0; JalPC = 32'd0;
  endtask

  task automatic cyc();
    @(negedge Clk);
  endtask

  task automatic check_queue(input string tag, input logic [36:0] exp[$]);
    check_eq({tag, "_count"}, 64'(wq.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < wq.size(); i++)
      check_eq($sformatf("%s_w%0d", tag, i), 64'(wq[i]), 64'(exp[i]));
  endtask

  initial begin
    logic [36:0] exp_q[$];

    // 1: reset holds everything idle even with a request presented
    idle();
    Rst_n = 1'b0; ReadReg1 = 5'd3; ReadReg2 = 5'd3;
    AluValid = 1'b1; AluReg = 5'd3; AluData = 32'h77;
    cyc(); cyc(); #1;
    check_eq("rst_regwrite", RegWrite, 0);
    check_eq("rst_stall", Stall, 0);
    check_eq("rst_busy1", Busy1, 0);
    check_eq("rst_busy2", Busy2, 0);
    check_eq("rst_wreg", WriteReg, 0);
    check_eq("rst_wdata", WriteData, 0);
    cyc(); idle(); Rst_n = 1'b1;
    cyc(); cyc(); cyc(); #1;
    check_eq("post_rst_regwrite", RegWrite, 0);
    check_eq("post_rst_writes", wq.size(), 0);

    // 2: single ALU write, latency and busy window
    cyc(); AluValid = 1'b1; AluReg = 5'd5; AluData = 32'h1234; ReadReg1 = 5'd5; #1;
    check_eq("alu_stall", Stall, 0);
    cyc(); idle(); #1;
    check_eq("alu_busy_n", Busy1, 1);
    check_eq("alu_rw_n", RegWrite, 0);
    cyc(); #1;
    check_eq("alu_rw_n1", RegWrite, 1);
    check_eq("alu_wreg", WriteReg, 5);
    check_eq("alu_wdata", WriteData, 32'h1234);
    check_eq("alu_busy_n1", Busy1, 1);
    cyc(); #1;
    check_eq("alu_rw_n2", RegWrite, 0);
    check_eq("alu_busy_n2", Busy1, 0);
    check_eq("alu_hold_wdata", WriteData, 32'h1234);

    // 3: same-cycle Jal/Ld/Alu to r31 retire in push order
    wq.delete();
    cyc(); JalValid = 1'b1; JalPC = 32'h40;
    LdValid = 1'b1; LdReg = 5'd31; LdData = 32'hAA;
    AluValid = 1'b1; AluReg = 5'd31; AluData = 32'hBB; ReadReg2 = 5'd31; #1;
    check_eq("waw_stall", Stall, 0);
    cyc(); idle(); #1;
    check_eq("waw_busy2", Busy2, 1);
    repeat (5) cyc();
    exp_q = '{{5'd31, 32'h41}, {5'd31, 32'hAA}, {5'd31, 32'hBB}};
    check_queue("waw", exp_q);

    // 4: fill to full, overflowing pair stalls, then goes in next cycle in order
    wq.delete();
    cyc(); JalValid = 1'b1; JalPC = 32'h100;
    LdValid = 1'b1; LdReg = 5'd1; LdData = 32'h11;
    AluValid = 1'b1; AluReg = 5'd2; AluData = 32'h22; #1;
    check_eq("fill_a_stall", Stall, 0);
    cyc(); idle();
    LdValid = 1'b1; LdReg = 5'd3; LdData = 32'h33;
    AluValid = 1'b1; AluReg = 5'd4; AluData = 32'h44; #1;
    check_eq("fill_b_stall", Stall, 0);
    cyc(); idle();
    LdValid = 1'b1; LdReg = 5'd5; LdData = 32'h55;
    AluValid = 1'b1; AluReg = 5'd6; AluData = 32'h66; #1;
    check_eq("full_stall", Stall, 1);
    cyc(); #1;
    check_eq("retry_stall", Stall, 0);
    cyc(); idle();
    repeat (10) cyc();
    exp_q = '{{5'd31, 32'h101}, {5'd1, 32'h11}, {5'd2, 32'h22}, {5'd3, 32'h33},
              {5'd4, 32'h44}, {5'd5, 32'h55}, {5'd6, 32'h66}};
    check_queue("full", exp_q);

    // 5: load scoreboard
    wq.delete();
    cyc(); LdIssue = 1'b1; LdIssueReg = 5'd7; ReadReg1 = 5'd7; #1;
    check_eq("ldi_stall", Stall, 0);
    check_eq("ldi_busy_pre", Busy1, 0);
    cyc(); #1;
    check_eq("ldi_busy", Busy1, 1);
    check_eq("ldi_dup_stall", Stall, 1);
    cyc(); idle(); #1;
    check_eq("ldi_busy_held", Busy1, 1);
    LdValid = 1'b1; LdReg = 5'd7; LdData = 32'h99; #1;
    check_eq("ldret_stall", Stall, 0);
    cyc(); idle(); #1;
    check_eq("ldret_busy_q", Busy1, 1);
    cyc(); #1;
    check_eq("ldret_rw", RegWrite, 1);
    check_eq("ldret_wreg", WriteReg, 7);
    check_eq("ldret_wdata", WriteData, 32'h99);
    check_eq("ldret_busy_rw", Busy1, 1);
    cyc(); #1;
    check_eq("ldret_busy_clr", Busy1, 0);

    // 6: reg0 drop and JalPC wrap
    wq.delete();
    cyc(); AluValid = 1'b1; AluReg = 5'd0; AluData = 32'h55; ReadReg1 = 5'd0; #1;
    check_eq("r0_stall", Stall, 0);
    check_eq("r0_busy", Busy1, 0);
    cyc(); idle();
    repeat (3) cyc(); #1;
    check_eq("r0_no_write", wq.size(), 0);
    JalValid = 1'b1; JalPC = 32'hFFFF_FFFF;
    cyc(); idle();
    repeat (3) cyc();
    exp_q = '{{5'd31, 32'h0}};
    check_queue("jal_wrap", exp_q);

    // Mid-operation reset discards queued and pending state
    wq.delete();
    cyc(); AluValid = 1'b1; AluReg = 5'd9; AluData = 32'h9;
    LdIssue = 1'b1; LdIssueReg = 5'd10; ReadReg1 = 5'd9; ReadReg2 = 5'd10;
    cyc(); idle(); Rst_n = 1'b0; #1;
    check_eq("mid_rst_busy1", Busy1, 0);
    check_eq("mid_rst_busy2", Busy2, 0);
    cyc(); Rst_n = 1'b1;
    repeat (3) cyc(); #1;
    check_eq("mid_rst_no_write", wq.size(), 0);
    check_eq("mid_rst_busy2_after", Busy2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
